// File: rtl/tick_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tick_pause_ctrl
// Description : Debounced pause/mode buttons driving a pausable tick divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_pause_ctrl #(
  parameter int CLK_DIV         = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_mode,
  output logic       tick,
  output logic       pause,
  output logic [1:0] mode,
  output logic       mode_changed
);

  localparam int c_div_w = $clog2(CLK_DIV);
  localparam int c_db_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
  localparam logic [c_db_w-1:0]  c_db_max  = c_db_w'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = pause button, bit 1 = mode button.
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_mode, btn_pause};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic              r_sync1;
      logic              r_sync2;
      logic              r_stable;
      logic              r_stable_d;
      logic [c_db_w-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_btn_raw[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_max) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // Only the rising edge of the accepted level counts as a press.
      assign w_press[gi] = r_stable & ~r_stable_d;
    end
  endgenerate

  logic               w_pause_press;
  logic               w_mode_press;
  logic               w_pause_next;
  logic               w_wrap;
  logic [c_div_w-1:0] r_div;
  logic               r_tick;
  logic               r_pause;
  logic [1:0]         r_mode;
  logic               r_mode_changed;

  assign w_pause_press = w_press[0];
  assign w_mode_press  = w_press[1];
  assign w_wrap        = (r_div == c_div_max);

  // Mode press wins over a simultaneous pause press and always unpauses.
  always_comb begin
    w_pause_next = r_pause;
    if (w_mode_press) begin
      w_pause_next = 1'b0;
    end else if (w_pause_press) begin
      w_pause_next = ~r_pause;
    end
  end

  // The divider only advances on edges that leave the block unpaused, so a
  // tick can never coincide with pause = 1 and the phase is held while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div          <= '0;
      r_tick         <= 1'b0;
      r_pause        <= 1'b0;
      r_mode         <= 2'd0;
      r_mode_changed <= 1'b0;
    end else begin
      r_pause        <= w_pause_next;
      r_mode_changed <= w_mode_press;
      if (w_mode_press) begin
        r_mode <= r_mode + 2'd1;
        r_div  <= '0;
        r_tick <= 1'b0;
      end else if (!w_pause_next) begin
        r_div  <= w_wrap ? '0 : r_div + 1'b1;
        r_tick <= w_wrap;
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

  assign tick         = r_tick;
  assign pause        = r_pause;
  assign mode         = r_mode;
  assign mode_changed = r_mode_changed;

endmodule
`default_nettype wire

// File: tb/tb_tick_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_pause_ctrl
// Description : Vector table, random reference-model run and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_pause_ctrl;

  localparam int c_clk_div = 4;
  localparam int c_db      = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_pause;
  logic       btn_mode;
  logic       tick;
  logic       pause;
  logic [1:0] mode;
  logic       mode_changed;

  int checks = 0;
  int errors = 0;

  tick_pause_ctrl #(
    .CLK_DIV        (c_clk_div),
    .DEBOUNCE_CYCLES(c_db)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_pause   (btn_pause),
    .btn_mode    (btn_mode),
    .tick        (tick),
    .pause       (pause),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a press is accepted once the synchronized level (raw
  // input two edges late) has disagreed with the accepted level for
  // DEBOUNCE_CYCLES consecutive edges since the last acceptance; the press
  // acts one edge later. Tick phase is a count of unpaused edges.
  int   m_e;
  logic m_rawp[$];
  logic m_rawm[$];
  int   m_last[2];
  logic m_stable[2];
  logic m_pend[2];
  logic m_pause;
  int   m_mode;
  int   m_phase;
  logic m_tick;
  logic m_mc;

  task automatic model_reset();
    m_e = 0;
    m_rawp.delete();
    m_rawm.delete();
    for (int b = 0; b < 2; b++) begin
      m_last[b]   = 0;
      m_stable[b] = 1'b0;
      m_pend[b]   = 1'b0;
    end
    m_pause = 1'b0;
    m_mode  = 0;
    m_phase = 0;
    m_tick  = 1'b0;
    m_mc    = 1'b0;
  endtask

  function automatic logic m_sync(input int b, input int e);
    if (e < 3) return 1'b0;
    return (b == 0) ? m_rawp[e-3] : m_rawm[e-3];
  endfunction

  task automatic model_edge(input logic bp, input logic bm);
    logic pp, pm, all_diff;
    m_e++;
    m_rawp.push_back(bp);
    m_rawm.push_back(bm);
    pp = m_pend[0];
    pm = m_pend[1];
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    if (pm) begin
      m_mode  = (m_mode + 1) % 4;
      m_pause = 1'b0;
      m_phase = 0;
      m_tick  = 1'b0;
      m_mc    = 1'b1;
    end else begin
      m_mc = 1'b0;
      if (pp) m_pause = !m_pause;
      if (!m_pause) begin
        m_phase++;
        m_tick = ((m_phase % c_clk_div) == 0);
      end else begin
        m_tick = 1'b0;
      end
    end
    for (int b = 0; b < 2; b++) begin
      if (m_e - m_last[b] >= c_db) begin
        all_diff = 1'b1;
        for (int j = 0; j < c_db; j++)
          if (m_sync(b, m_e - j) == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[b] = !m_stable[b];
          m_last[b]   = m_e;
          if (m_stable[b]) m_pend[b] = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    logic       bp;
    logic       bm;
    int         cycles;
    logic       exp_pause;
    logic [1:0] exp_mode;
    int         exp_ticks;
    int         exp_mc;
    logic       exp_tick_last;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int ticks, mcs, hold;

    // Each record holds the buttons for some cycles, then checks the end state
    // and the number of tick / mode_changed pulses seen during the segment.
    tbl[0]  = '{1'b0, 1'b0,  8, 1'b0, 2'd0, 2, 0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 10, 1'b1, 2'd0, 1, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 10, 1'b1, 2'd0, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10, 1'b0, 2'd0, 1, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 10, 1'b0, 2'd0, 3, 0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0,  2, 1'b0, 2'd0, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0,  6, 1'b0, 2'd0, 2, 0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1,  5, 1'b0, 2'd0, 1, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0,  5, 1'b0, 2'd1, 1, 1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1,  5, 1'b0, 2'd1, 1, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b0,  5, 1'b0, 2'd2, 1, 1, 1'b1};
    tbl[11] = '{1'b0, 1'b1,  5, 1'b0, 2'd2, 1, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b0,  5, 1'b0, 2'd3, 1, 1, 1'b1};
    tbl[13] = '{1'b0, 1'b1,  5, 1'b0, 2'd3, 1, 0, 1'b0};
    tbl[14] = '{1'b0, 1'b0,  5, 1'b0, 2'd0, 1, 1, 1'b1};
    tbl[15] = '{1'b1, 1'b0,  6, 1'b1, 2'd0, 1, 0, 1'b0};
    tbl[16] = '{1'b0, 1'b0,  4, 1'b1, 2'd0, 0, 0, 1'b0};
    tbl[17] = '{1'b0, 1'b1,  5, 1'b1, 2'd0, 0, 0, 1'b0};
    tbl[18] = '{1'b0, 1'b0,  5, 1'b0, 2'd1, 1, 1, 1'b1};
    tbl[19] = '{1'b1, 1'b1,  5, 1'b0, 2'd1, 1, 0, 1'b0};
    tbl[20] = '{1'b0, 1'b0,  5, 1'b0, 2'd2, 1, 1, 1'b1};

    reset     = 1'b0;
    btn_pause = 1'b0;
    btn_mode  = 1'b0;
    repeat (3) step();
    check("reset tick", int'(tick), 0);
    check("reset pause", int'(pause), 0);
    check("reset mode", int'(mode), 0);
    check("reset mode_changed", int'(mode_changed), 0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      btn_pause = tbl[i].bp;
      btn_mode  = tbl[i].bm;
      ticks = 0;
      mcs   = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        step();
        ticks += int'(tick);
        mcs   += int'(mode_changed);
      end
      check($sformatf("vec%0d pause", i), int'(pause), int'(tbl[i].exp_pause));
      check($sformatf("vec%0d mode", i), int'(mode), int'(tbl[i].exp_mode));
      check($sformatf("vec%0d ticks", i), ticks, tbl[i].exp_ticks);
      check($sformatf("vec%0d mode_changed", i), mcs, tbl[i].exp_mc);
      check($sformatf("vec%0d tick_last", i), int'(tick), int'(tbl[i].exp_tick_last));
    end

    // Randomized run against the reference model.
    btn_pause = 1'b0;
    btn_mode  = 1'b0;
    reset     = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        btn_pause = 1'($urandom_range(0, 1));
        btn_mode  = ($urandom_range(0, 3) == 0);
        hold      = $urandom_range(1, 10);
      end
      hold--;
      model_edge(btn_pause, btn_mode);
      step();
      check($sformatf("rnd%0d tick", c), int'(tick), int'(m_tick));
      check($sformatf("rnd%0d pause", c), int'(pause), int'(m_pause));
      check($sformatf("rnd%0d mode", c), int'(mode), m_mode);
      check($sformatf("rnd%0d mode_changed", c), int'(mode_changed), int'(m_mc));
      check($sformatf("rnd%0d tick_and_mc", c), int'(tick & mode_changed), 0);
    end

    // Reach mode 2 / paused, then reset asynchronously in the middle of a press.
    btn_pause = 1'b0;
    btn_mode  = 1'b0;
    reset     = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      btn_mode = 1'b1;
      repeat (6) step();
      btn_mode = 1'b0;
      repeat (6) step();
    end
    btn_pause = 1'b1;
    repeat (6) step();
    btn_pause = 1'b0;
    repeat (6) step();
    check("pre-reset mode", int'(mode), 2);
    check("pre-reset pause", int'(pause), 1);
    btn_pause = 1'b1;
    repeat (4) step();
    #2;
    reset = 1'b0;
    #1;
    check("async tick", int'(tick), 0);
    check("async pause", int'(pause), 0);
    check("async mode", int'(mode), 0);
    check("async mode_changed", int'(mode_changed), 0);
    btn_pause = 1'b0;
    step();
    reset = 1'b1;
    repeat (8) step();
    check("lost press pause", int'(pause), 0);
    check("lost press mode", int'(mode), 0);

    // Mode button held through reset release registers exactly once.
    reset    = 1'b0;
    btn_mode = 1'b1;
    step();
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) check("held tick edge3", int'(tick), 0);
      if (k == 4) check("held tick edge4", int'(tick), 1);
      if (k == 5) check("held mode edge5", int'(mode), 0);
      if (k == 6) begin
        check("held mode edge6", int'(mode), 1);
        check("held mode_changed edge6", int'(mode_changed), 1);
      end
    end
    repeat (10) step();
    check("held single press mode", int'(mode), 1);
    btn_mode = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
